// File: rtl/cond_ctrl_pipe_pkg.sv
// Shared definitions for the condition/control pipeline: ARM condition
// codes, NZCV bit positions and the flag-hazard FSM encoding.
package cond_ctrl_pipe_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_READY   = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

endpackage

// File: rtl/cond_ctrl_pipe_if.sv
// Decoder-side bus of the condition/control pipeline: instruction
// handshake, ALU flag return and the registered control outputs.
interface cond_ctrl_pipe_if #(
  parameter int GROUPS = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        Cond;
  logic [GROUPS-1:0] FlagW;
  logic              PCS;
  logic              RegW;
  logic              MemW;
  logic              NoWrite;
  logic [3:0]        ALUFlags;
  logic              alu_valid;
  logic              out_valid;
  logic              out_ready;
  logic              PCSrc;
  logic              RegWrite;
  logic              MemWrite;
  logic              CondEx;
  logic [GROUPS-1:0] FlagWrite;
  logic [3:0]        Flags;

  modport master (
    output in_valid, Cond, FlagW, PCS, RegW, MemW, NoWrite,
    output ALUFlags, alu_valid, out_ready,
    input  in_ready, out_valid, PCSrc, RegWrite, MemWrite, CondEx,
    input  FlagWrite, Flags
  );

  modport slave (
    input  in_valid, Cond, FlagW, PCS, RegW, MemW, NoWrite,
    input  ALUFlags, alu_valid, out_ready,
    output in_ready, out_valid, PCSrc, RegWrite, MemWrite, CondEx,
    output FlagWrite, Flags
  );
endinterface

// File: rtl/cond_ctrl_pipe_cond_eval.sv
// Purely combinational ARM condition-code evaluator over NZCV.
module cond_eval
  import cond_ctrl_pipe_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Decode the condition field; the unused 1111 encoding executes always.
  always_comb begin
    CondEx = 1'b1;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_ctrl_pipe.sv
// Condition-check and control-gating stage with architectural NZCV flags,
// a flag-hazard interlock and an optional ALU-flag bypass.
module cond_ctrl_pipe #(
  parameter int GROUPS = 2,
  parameter int FWD    = 1
) (
  input logic            clk,
  input logic            reset,
  cond_ctrl_pipe_if.slave bus
);
  import cond_ctrl_pipe_pkg::*;

  localparam int GW = 4 / GROUPS;

  // Spread a per-group mask onto the four flag bits it covers.
  function automatic logic [3:0] group_bits(input logic [GROUPS-1:0] m);
    logic [3:0] r;
    for (int b = 0; b < 4; b++) r[b] = m[b / GW];
    return r;
  endfunction

  state_t            state_p1;
  logic [GROUPS-1:0] pend_mask_p1;
  logic [3:0]        flags_q;
  logic [3:0]        flags_eff_p0;
  logic              condex_p0;
  logic              out_stall;
  logic              alu_take;
  logic              in_ready_c;
  logic              accept_p0;
  logic [GROUPS-1:0] fw_p0;

  logic              vld_p1;
  logic              pcsrc_p1;
  logic              regwrite_p1;
  logic              memwrite_p1;
  logic              condex_p1;
  logic [GROUPS-1:0] flagwrite_p1;

  // ---- stage p0: hazard check, flag bypass and condition evaluation ----
  // Handshake and effective flags seen by the incoming instruction.
  always_comb begin
    out_stall    = vld_p1 & ~bus.out_ready;
    alu_take     = (state_p1 == ST_PENDING) & bus.alu_valid;
    in_ready_c   = 1'b0;
    flags_eff_p0 = flags_q;
    if (state_p1 == ST_READY)
      in_ready_c = ~out_stall;
    else if (bus.alu_valid && FWD != 0)
      in_ready_c = ~out_stall;
    if (FWD != 0 && alu_take)
      flags_eff_p0 = (flags_q & ~group_bits(pend_mask_p1)) |
                     (bus.ALUFlags & group_bits(pend_mask_p1));
  end

  cond_eval u_cond_eval (
    .Cond   (bus.Cond),
    .flags  (flags_eff_p0),
    .CondEx (condex_p0)
  );

  assign accept_p0 = bus.in_valid & in_ready_c;
  assign fw_p0     = bus.FlagW & {GROUPS{condex_p0}};

  // Architectural flags: one independently enabled register per group.
  for (genvar g = 0; g < GROUPS; g++) begin : g_flag
    logic [GW-1:0] grp_q;

    // Load this group from the ALU only when the pending writer owns it.
    always_ff @(posedge clk) begin
      if (!reset)
        grp_q <= '0;
      else if (alu_take && pend_mask_p1[g])
        grp_q <= bus.ALUFlags[g*GW +: GW];
    end

    assign flags_q[g*GW +: GW] = grp_q;
  end

  // Flag-hazard FSM: PENDING while a flag writer awaits its ALU result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_p1     <= ST_READY;
      pend_mask_p1 <= '0;
    end else begin
      case (state_p1)
        ST_READY: begin
          if (accept_p0 && |fw_p0) begin
            state_p1     <= ST_PENDING;
            pend_mask_p1 <= fw_p0;
          end
        end
        ST_PENDING: begin
          if (bus.alu_valid) begin
            if (accept_p0 && |fw_p0) begin
              pend_mask_p1 <= fw_p0;
            end else begin
              state_p1     <= ST_READY;
              pend_mask_p1 <= '0;
            end
          end
        end
        default: begin
          state_p1     <= ST_READY;
          pend_mask_p1 <= '0;
        end
      endcase
    end
  end

  // ---- stage p1: registered, condition-gated control outputs ----
  // Capture on acceptance, hold while stalled, drop valid once consumed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p1       <= 1'b0;
      pcsrc_p1     <= 1'b0;
      regwrite_p1  <= 1'b0;
      memwrite_p1  <= 1'b0;
      condex_p1    <= 1'b0;
      flagwrite_p1 <= '0;
    end else if (accept_p0) begin
      vld_p1       <= 1'b1;
      pcsrc_p1     <= bus.PCS & condex_p0;
      regwrite_p1  <= bus.RegW & condex_p0 & ~bus.NoWrite;
      memwrite_p1  <= bus.MemW & condex_p0;
      condex_p1    <= condex_p0;
      flagwrite_p1 <= fw_p0;
    end else if (bus.out_ready) begin
      vld_p1       <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = vld_p1;
  assign bus.PCSrc     = pcsrc_p1;
  assign bus.RegWrite  = regwrite_p1;
  assign bus.MemWrite  = memwrite_p1;
  assign bus.CondEx    = condex_p1;
  assign bus.FlagWrite = flagwrite_p1;
  assign bus.Flags     = flags_q;

endmodule

// File: tb/tb_cond_ctrl_pipe.sv
// Directed bench for cond_ctrl_pipe: a scoreboard checks every output
// handshake of the bypassing instance, plus direct checks of stalls, flags
// and a non-bypassing instance.
module tb_cond_ctrl_pipe;

  logic clk = 1'b0;
  logic reset;

  cond_ctrl_pipe_if #(.GROUPS(2)) a ();
  cond_ctrl_pipe_if #(.GROUPS(2)) b ();

  cond_ctrl_pipe #(.GROUPS(2), .FWD(1)) dut_a (.clk(clk), .reset(reset), .bus(a));
  cond_ctrl_pipe #(.GROUPS(2), .FWD(0)) dut_b (.clk(clk), .reset(reset), .bus(b));

  always #5 clk = ~clk;

  int         nvec = 0;
  int         nerr = 0;
  logic [5:0] exp_q[$];
  logic [5:0] pend;

  function automatic logic [5:0] E(input logic p, input logic r, input logic m,
                                   input logic c, input logic [1:0] f);
    return {p, r, m, c, f};
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic offer(input logic [3:0] c, input logic [1:0] fw, input logic p,
                       input logic r, input logic m, input logic nw,
                       input logic [5:0] e);
    a.Cond = c; a.FlagW = fw; a.PCS = p; a.RegW = r; a.MemW = m; a.NoWrite = nw;
    a.in_valid = 1'b1;
    pend = e;
  endtask

  // One cycle: record an acceptance (expected result into the scoreboard).
  task automatic tick();
    logic acc;
    acc = 1'b0;
    @(negedge clk);
    if (a.in_valid && a.in_ready) begin
      exp_q.push_back(pend);
      acc = 1'b1;
    end
    @(posedge clk); #1;
    if (acc) a.in_valid = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    a.in_valid = 0; a.Cond = 0; a.FlagW = 0; a.PCS = 0; a.RegW = 0; a.MemW = 0;
    a.NoWrite = 0; a.ALUFlags = 0; a.alu_valid = 0; a.out_ready = 1;
    b.in_valid = 0; b.Cond = 0; b.FlagW = 0; b.PCS = 0; b.RegW = 0; b.MemW = 0;
    b.NoWrite = 0; b.ALUFlags = 0; b.alu_valid = 0; b.out_ready = 1;

    fork
      begin : monitor
        logic [5:0] e;
        logic [5:0] got;
        forever begin
          @(negedge clk);
          if (a.out_valid && a.out_ready) begin
            nvec++;
            got = {a.PCSrc, a.RegWrite, a.MemWrite, a.CondEx, a.FlagWrite};
            if (exp_q.size() == 0) begin
              nerr++;
              $display("FAIL unexpected_output: got pcs/rw/mw/cx/fw=%b required none", got);
            end else begin
              e = exp_q.pop_front();
              if (got !== e) begin
                nerr++;
                $display("FAIL output: got pcs/rw/mw/cx/fw=%b required %b", got, e);
              end
            end
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", int'(a.out_valid), 0);
    chk("rst_flags", int'(a.Flags), 0);
    chk("rst_in_ready", int'(a.in_ready), 1);
    chk("rst_regwrite", int'(a.RegWrite), 0);
    chk("rst_flagwrite", int'(a.FlagWrite), 0);
    nxt();

    // Flags = 0000
    offer(4'b0000, 2'b00, 0, 1, 0, 0, E(0, 0, 0, 0, 2'b00)); tick();
    offer(4'b0001, 2'b00, 0, 1, 0, 0, E(0, 1, 0, 1, 2'b00)); tick();
    offer(4'b0010, 2'b00, 0, 1, 0, 0, E(0, 0, 0, 0, 2'b00)); tick();
    offer(4'b0011, 2'b00, 0, 0, 1, 0, E(0, 0, 1, 1, 2'b00)); tick();
    offer(4'b1010, 2'b00, 0, 1, 0, 0, E(0, 1, 0, 1, 2'b00)); tick();
    offer(4'b1000, 2'b00, 1, 0, 0, 0, E(0, 0, 0, 0, 2'b00)); tick();
    offer(4'b1101, 2'b00, 0, 1, 1, 0, E(0, 0, 0, 0, 2'b00)); tick();
    offer(4'b1111, 2'b00, 1, 1, 0, 1, E(1, 0, 0, 1, 2'b00)); tick();
    // Failed condition with flag-write request: no hazard afterwards
    offer(4'b0000, 2'b11, 0, 1, 0, 0, E(0, 0, 0, 0, 2'b00)); tick();
    @(negedge clk);
    chk("condfail_no_pending", int'(a.in_ready), 1);
    nxt();

    // CMP, two stall cycles, then ALU flags 0100
    offer(4'b1110, 2'b11, 0, 0, 0, 0, E(0, 0, 0, 1, 2'b11)); tick();
    @(negedge clk); chk("stall1_in_ready", int'(a.in_ready), 0); nxt();
    @(negedge clk); chk("stall2_in_ready", int'(a.in_ready), 0); nxt();
    a.alu_valid = 1; a.ALUFlags = 4'b0100;
    @(negedge clk); chk("alu_cycle_in_ready", int'(a.in_ready), 1); nxt();
    a.alu_valid = 0;
    @(negedge clk);
    chk("cmp_flags", int'(a.Flags), 4'b0100);
    chk("cmp_ready_after", int'(a.in_ready), 1);
    nxt();

    // Flags = 0100 (Z)
    offer(4'b0000, 2'b00, 0, 1, 0, 0, E(0, 1, 0, 1, 2'b00)); tick();
    offer(4'b1100, 2'b00, 0, 1, 0, 0, E(0, 0, 0, 0, 2'b00)); tick();
    offer(4'b1001, 2'b00, 1, 0, 0, 0, E(1, 0, 0, 1, 2'b00)); tick();
    offer(4'b0100, 2'b00, 0, 0, 1, 0, E(0, 0, 0, 0, 2'b00)); tick();

    // Bypass: forwarded Z=0 must beat stale Z=1
    offer(4'b1110, 2'b11, 0, 0, 0, 0, E(0, 0, 0, 1, 2'b11)); tick();
    a.alu_valid = 1; a.ALUFlags = 4'b0000;
    offer(4'b0000, 2'b00, 1, 0, 0, 0, E(0, 0, 0, 0, 2'b00)); tick();
    a.alu_valid = 0;
    @(negedge clk); chk("fwd_flags0", int'(a.Flags), 0); nxt();
    // Bypass: BEQ with forwarded Z=1
    offer(4'b1110, 2'b11, 0, 0, 0, 0, E(0, 0, 0, 1, 2'b11)); tick();
    a.alu_valid = 1; a.ALUFlags = 4'b0100;
    offer(4'b0000, 2'b00, 1, 0, 0, 0, E(1, 0, 0, 1, 2'b00)); tick();
    a.alu_valid = 0;

    // Back-to-back flag writers, second one only updates {C,V}
    offer(4'b1110, 2'b11, 0, 0, 0, 0, E(0, 0, 0, 1, 2'b11)); tick();
    a.alu_valid = 1; a.ALUFlags = 4'b1000;
    offer(4'b1110, 2'b01, 0, 0, 0, 0, E(0, 0, 0, 1, 2'b01)); tick();
    a.alu_valid = 0;
    @(negedge clk);
    chk("chain_still_pending", int'(a.in_ready), 0);
    chk("chain_flags_mid", int'(a.Flags), 4'b1000);
    nxt();
    a.alu_valid = 1; a.ALUFlags = 4'b0011;
    tick();
    a.alu_valid = 0;
    @(negedge clk);
    chk("group_flags", int'(a.Flags), 4'b1011);
    chk("group_ready", int'(a.in_ready), 1);
    nxt();

    // Output backpressure for three cycles
    a.out_ready = 0;
    offer(4'b1110, 2'b00, 0, 1, 0, 0, E(0, 1, 0, 1, 2'b00)); tick();
    offer(4'b0001, 2'b00, 0, 0, 1, 0, E(0, 0, 1, 1, 2'b00));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(a.in_ready), 0);
      chk("bp_out_valid", int'(a.out_valid), 1);
      chk("bp_hold", int'({a.RegWrite, a.MemWrite, a.CondEx}), 3'b101);
      nxt();
    end
    a.out_ready = 1;
    tick();
    tick();

    // Reset while PENDING
    offer(4'b1110, 2'b11, 0, 0, 0, 0, E(0, 0, 0, 1, 2'b11)); tick();
    reset = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    a.alu_valid = 1; a.ALUFlags = 4'b1111;
    @(negedge clk);
    chk("rstp_out_valid", int'(a.out_valid), 0);
    chk("rstp_flags", int'(a.Flags), 0);
    chk("rstp_in_ready", int'(a.in_ready), 1);
    nxt();
    a.alu_valid = 0;
    @(negedge clk); chk("rstp_alu_ignored", int'(a.Flags), 0); nxt();

    // Non-bypassing instance: BEQ waits one cycle past the ALU return
    b.Cond = 4'b1110; b.FlagW = 2'b11; b.in_valid = 1;
    @(negedge clk); chk("b_cmp_ready", int'(b.in_ready), 1); nxt();
    b.alu_valid = 1; b.ALUFlags = 4'b0100;
    b.Cond = 4'b0000; b.FlagW = 2'b00; b.PCS = 1;
    @(negedge clk);
    chk("b_nofwd_ready", int'(b.in_ready), 0);
    chk("b_cmp_out", int'({b.out_valid, b.FlagWrite}), 3'b111);
    nxt();
    b.alu_valid = 0;
    @(negedge clk);
    chk("b_ready_after", int'(b.in_ready), 1);
    chk("b_flags", int'(b.Flags), 4'b0100);
    nxt();
    b.in_valid = 0;
    @(negedge clk);
    chk("b_beq_out", int'({b.out_valid, b.PCSrc, b.CondEx}), 3'b111);
    nxt();

    nxt(); nxt();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cond_ctrl_pipe.md
COND_CTRL_PIPE -- requirements
Module: cond_ctrl_pipe

Interface
REQ-001 Parameter GROUPS, default 2: number of independently enabled flag-write groups over NZCV; legal values 1, 2, 4.
REQ-002 Parameter FWD, default 1: 1 = ALU flags bypassed to condition check in the cycle they return; 0 = no bypass.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 in_valid  in  1  decoded instruction present; in_ready  out  1  instruction accepted when both high.
REQ-006 Cond  in  4  condition field; FlagW  in  GROUPS  per-group flag-write request; PCS, RegW, MemW, NoWrite  in  1 each  decoder controls.
REQ-007 ALUFlags  in  4  {N,Z,C,V} of the oldest flag-writing instruction; alu_valid  in  1  ALUFlags valid this cycle.
REQ-008 out_valid  out  1; out_ready  in  1  output handshake.
REQ-009 PCSrc, RegWrite, MemWrite, CondEx  out  1 each; FlagWrite  out  GROUPS; Flags  out  4  architectural flags.

Function
REQ-010 Group g covers flag bits [(g+1)*4/GROUPS-1 : g*4/GROUPS]; GROUPS=2 gives {N,Z} and {C,V}.
REQ-011 CondEx SHALL follow ARM encoding: 0000 EQ Z, 0001 NE, 0010 CS C, 0011 CC, 0100 MI N, 0101 PL, 0110 VS V, 0111 VC, 1000 HI C&~Z, 1001 LS, 1010 GE N==V, 1011 LT, 1100 GT ~Z&(N==V), 1101 LE, 1110 AL 1, 1111 treated as 1.
REQ-012 Condition evaluated at acceptance against the effective flags: Flags, or, when FWD=1 and alu_valid in PENDING, Flags merged with ALUFlags over the pending groups.
REQ-013 Outputs registered: accepted instruction appears with out_valid=1 exactly 1 cycle later; RegWrite=RegW&CondEx&~NoWrite, MemWrite=MemW&CondEx, PCSrc=PCS&CondEx, FlagWrite=FlagW&{GROUPS{CondEx}}.
REQ-014 Output register holds all values stable while out_valid&~out_ready; in_ready low in that case.
REQ-015 FSM states READY and PENDING; PENDING records pend_mask = FlagWrite of the accepted flag-writing instruction.
REQ-016 READY: in_ready = ~(out_valid&~out_ready); acceptance with FlagWrite!=0 -> PENDING.
REQ-017 PENDING, alu_valid=0: in_ready=0 (flag hazard stall).
REQ-018 PENDING, alu_valid=1: Flags groups in pend_mask load ALUFlags; others hold; with FWD=1 in_ready per REQ-016 same cycle, with FWD=0 in_ready=0.
REQ-019 PENDING, alu_valid=1 with simultaneous acceptance of a flag-writing instruction -> remain PENDING with new pend_mask; otherwise -> READY.
REQ-020 alu_valid in READY SHALL be ignored (no Flags change).
REQ-021 Instruction with CondEx=0 still passes through (out_valid=1) with all enables 0, never enters PENDING.

Reset
REQ-022 reset=0 at a clock edge: state READY, pend_mask 0, Flags 4'b0000, out_valid 0, all registered enables 0; in_ready 1 after reset releases.
REQ-023 Reset mid-PENDING or with stalled output discards the pending instruction and result; no Flags update on that edge.

Structure
REQ-024 Shared package holds condition-code constants (EQ..AL), flag bit indices N=3,Z=2,C=1,V=0, and FSM state encoding.
REQ-025 Combinational sub-module cond_eval (Cond, flags -> CondEx) SHALL be instantiated once.
REQ-026 Flag storage uses one enable-gated register per group.

Verification
REQ-027 Reset, Flags=0000, Cond=0000 (EQ), RegW=1 -> next cycle CondEx=0, RegWrite=0; Cond=0001 -> RegWrite=1.
REQ-028 GROUPS=2: CMP accepted with FlagW=11, Cond=1110; ALUFlags=0100, alu_valid 2 cycles later -> in_ready 0 for 2 cycles, Flags=0100 after.
REQ-029 FWD=1: PENDING, alu_valid with ALUFlags=0100, BEQ (Cond=0000, PCS=1) accepted same cycle -> PCSrc=1 next cycle; FWD=0 -> accepted one cycle later, PCSrc=1.
REQ-030 FlagW=01 only, Flags=1000, ALUFlags=0011 -> Flags=1011.
REQ-031 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; release -> next instruction 1 cycle later.
REQ-032 reset=0 asserted in PENDING -> next cycle READY, Flags=0000, out_valid=0; later alu_valid ignored.
